core_lsu_ctrl: RTL and testbench

//  Load/store sequencer between the execute stage and the data-memory port.
//  - Accepts one load/store at a time and checks alignment.
//  - Drives a valid/ready memory request with a doubleword-aligned address and byte strobes.
//  - Waits for the memory response, then byte-aligns and sign/zero-extends load data.
//  - Returns a one-cycle response pulse to the pipeline.

---
 rtl/core_lsu_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_core_lsu_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// core_lsu_ctrl
//   Load/store sequencer between the execute stage and the data-memory port.
//   Takes one load/store at a time, rejects size-misaligned addresses without
//   touching memory, issues a doubleword-aligned valid/ready request with byte
//   strobes, waits for the memory response, then byte-aligns and sign/zero-
//   extends load data and returns a one-cycle response pulse.
//
//   Optional feature macro: LSU_TIMEOUT_EN
//     defined   : a WAIT-state counter raises o_lsu_err after TIMEOUT_CYC
//                 WAIT cycles without a response (a response arriving in the
//                 terminal cycle wins).
//     undefined : WAIT lasts until the response; o_lsu_err is constant 0.
//
//   Parameters
//     XLEN         data/address width (only 64 is supported)
//     TIMEOUT_CYC  WAIT cycles before a bus error (LSU_TIMEOUT_EN only)
//
//   Ports
//     i_clk, i_rst_n            clock (rising edge), async active-low reset
//     i_lsu_req_valid/o_lsu_req_ready  pipeline request handshake (ready = IDLE)
//     i_lsu_we, i_lsu_addr, i_lsu_size, i_lsu_su_extend, i_lsu_wdata
//                               request fields (store flag, byte address,
//                               B/H/W/D size, zero-extend select, store data)
//     o_lsu_rsp_valid           one-cycle response pulse
//     o_lsu_rdata               extended load data (0 for stores/errors)
//     o_lsu_misalign, o_lsu_err response qualifiers
//     o_mem_req_valid/i_mem_req_ready  memory request handshake
//     o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wstrb  memory request fields
//     i_mem_rsp_valid, i_mem_rdata     memory response (sampled only in WAIT)
// -----------------------------------------------------------------------------
module core_lsu_ctrl #(
  parameter int XLEN        = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lsu_req_valid,
  output logic              o_lsu_req_ready,
  input  logic              i_lsu_we,
  input  logic [XLEN-1:0]   i_lsu_addr,
  input  logic [1:0]        i_lsu_size,
  input  logic              i_lsu_su_extend,
  input  logic [XLEN-1:0]   i_lsu_wdata,
  output logic              o_lsu_rsp_valid,
  output logic [XLEN-1:0]   o_lsu_rdata,
  output logic              o_lsu_misalign,
  output logic              o_lsu_err,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic              o_mem_we,
  output logic [XLEN-1:0]   o_mem_addr,
  output logic [XLEN-1:0]   o_mem_wdata,
  output logic [XLEN/8-1:0] o_mem_wstrb,
  input  logic              i_mem_rsp_valid,
  input  logic [XLEN-1:0]   i_mem_rdata
);

  if (XLEN != 64 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("core_lsu_ctrl: XLEN must be 64 and TIMEOUT_CYC must be >= 1");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Address not a multiple of the access size.
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      2'b10:   is_misaligned = |off[1:0];
      default: is_misaligned = |off;
    endcase
  endfunction

  // Replicate the LSB-justified store data into every lane of its size.
  function automatic logic [XLEN-1:0] store_lanes(input logic [XLEN-1:0] wd, input logic [1:0] size);
    case (size)
      2'b00:   store_lanes = {8{wd[7:0]}};
      2'b01:   store_lanes = {4{wd[15:0]}};
      2'b10:   store_lanes = {2{wd[31:0]}};
      default: store_lanes = wd;
    endcase
  endfunction

  function automatic logic [XLEN/8-1:0] store_strobes(input logic [2:0] off, input logic [1:0] size);
    logic [XLEN/8-1:0] base;
    case (size)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      2'b10:   base = 8'h0F;
      default: base = 8'hFF;
    endcase
    store_strobes = base << off;
  endfunction

  // Shift the addressed lane down to bit 0, then push it to the top and
  // shift back: arithmetic shift sign-extends, logical shift zero-extends.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rd,
                                                  input logic [2:0]      off,
                                                  input logic [1:0]      size,
                                                  input logic            su);
    logic [XLEN-1:0]        raw;
    logic [XLEN-1:0]        left;
    logic signed [XLEN-1:0] ext_s;
    logic [5:0]             sh_up;
    raw = rd >> {off, 3'b000};
    case (size)
      2'b00:   sh_up = 6'd56;
      2'b01:   sh_up = 6'd48;
      2'b10:   sh_up = 6'd32;
      default: sh_up = 6'd0;
    endcase
    left  = raw << sh_up;
    ext_s = $signed(left) >>> sh_up;
    load_extend = su ? (left >> sh_up) : ext_s;
  endfunction

  logic [1:0]        state;

  logic [XLEN-1:0]   mem_addr_p0;
  logic [XLEN-1:0]   mem_wdata_p0;
  logic [XLEN/8-1:0] mem_wstrb_p0;
  logic              we_p0;
  logic              su_p0;
  logic [1:0]        size_p0;
  logic [2:0]        off_p0;

  logic [XLEN-1:0]   rdata_p1;
  logic              misalign_p1;

  logic              tmo_hit;

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_p1;

  // tmo_cnt holds the number of response-less WAIT cycles already spent,
  // so the terminal compare fires in the TIMEOUT_CYC-th WAIT cycle.
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt <= '0;
      err_p1  <= 1'b0;
    end else begin
      if (state == ST_REQ && i_mem_req_ready) begin
        tmo_cnt <= '0;
      end else if (state == ST_WAIT && !i_mem_rsp_valid && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (state == ST_IDLE && i_lsu_req_valid) begin
        err_p1 <= 1'b0;
      end else if (state == ST_WAIT) begin
        if (i_mem_rsp_valid) begin
          err_p1 <= 1'b0;
        end else if (tmo_hit) begin
          err_p1 <= 1'b1;
        end
      end
    end
  end

  assign o_lsu_err = err_p1;
`else
  assign tmo_hit   = 1'b0;
  assign o_lsu_err = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      mem_addr_p0  <= '0;
      mem_wdata_p0 <= '0;
      mem_wstrb_p0 <= '0;
      we_p0        <= 1'b0;
      su_p0        <= 1'b0;
      size_p0      <= 2'b00;
      off_p0       <= 3'b000;
      rdata_p1     <= '0;
      misalign_p1  <= 1'b0;
    end else begin
      case (state)
        // p0: capture the request and build the memory-side fields
        ST_IDLE: begin
          if (i_lsu_req_valid) begin
            mem_addr_p0  <= {i_lsu_addr[XLEN-1:3], 3'b000};
            mem_wdata_p0 <= store_lanes(i_lsu_wdata, i_lsu_size);
            mem_wstrb_p0 <= i_lsu_we ? store_strobes(i_lsu_addr[2:0], i_lsu_size) : '1;
            we_p0        <= i_lsu_we;
            su_p0        <= i_lsu_su_extend;
            size_p0      <= i_lsu_size;
            off_p0       <= i_lsu_addr[2:0];
            if (is_misaligned(i_lsu_addr[2:0], i_lsu_size)) begin
              misalign_p1 <= 1'b1;
              rdata_p1    <= '0;
              state       <= ST_RESP;
            end else begin
              misalign_p1 <= 1'b0;
              state       <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (i_mem_req_ready) begin
            state <= ST_WAIT;
          end
        end
        // p1: memory response -> aligned, extended result
        ST_WAIT: begin
          if (i_mem_rsp_valid) begin
            rdata_p1 <= we_p0 ? '0 : load_extend(i_mem_rdata, off_p0, size_p0, su_p0);
            state    <= ST_RESP;
          end else if (tmo_hit) begin
            rdata_p1 <= '0;
            state    <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_lsu_req_ready = (state == ST_IDLE);
  assign o_lsu_rsp_valid = (state == ST_RESP);
  assign o_lsu_rdata     = rdata_p1;
  assign o_lsu_misalign  = misalign_p1;

  assign o_mem_req_valid = (state == ST_REQ);
  assign o_mem_we        = we_p0;
  assign o_mem_addr      = mem_addr_p0;
  assign o_mem_wdata     = mem_wdata_p0;
  assign o_mem_wstrb     = mem_wstrb_p0;

endmodule

// File: tb/tb_core_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_lsu_ctrl
//   Directed bench for core_lsu_ctrl. A byte-level model derives the expected
//   memory request, response data, flags and latency of each transaction; a
//   compare task run every cycle checks the DUT against it, and each vector
//   also pins the model to hand-computed literals.
// -----------------------------------------------------------------------------
module tb_core_lsu_ctrl;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_lsu_req_valid;
  logic        o_lsu_req_ready;
  logic        i_lsu_we;
  logic [63:0] i_lsu_addr;
  logic [1:0]  i_lsu_size;
  logic        i_lsu_su_extend;
  logic [63:0] i_lsu_wdata;
  logic        o_lsu_rsp_valid;
  logic [63:0] o_lsu_rdata;
  logic        o_lsu_misalign;
  logic        o_lsu_err;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic        o_mem_we;
  logic [63:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_wstrb;
  logic        i_mem_rsp_valid;
  logic [63:0] i_mem_rdata;

  core_lsu_ctrl #(.XLEN(64), .TIMEOUT_CYC(TMO)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_lsu_req_valid (i_lsu_req_valid),
    .o_lsu_req_ready (o_lsu_req_ready),
    .i_lsu_we        (i_lsu_we),
    .i_lsu_addr      (i_lsu_addr),
    .i_lsu_size      (i_lsu_size),
    .i_lsu_su_extend (i_lsu_su_extend),
    .i_lsu_wdata     (i_lsu_wdata),
    .o_lsu_rsp_valid (o_lsu_rsp_valid),
    .o_lsu_rdata     (o_lsu_rdata),
    .o_lsu_misalign  (o_lsu_misalign),
    .o_lsu_err       (o_lsu_err),
    .o_mem_req_valid (o_mem_req_valid),
    .i_mem_req_ready (i_mem_req_ready),
    .o_mem_we        (o_mem_we),
    .o_mem_addr      (o_mem_addr),
    .o_mem_wdata     (o_mem_wdata),
    .o_mem_wstrb     (o_mem_wstrb),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .i_mem_rdata     (i_mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rsp_cnt = 0;
  int accept_cyc = 0;
  bit in_flight = 1'b0;
  bit req_phase = 1'b0;

  // expectations for the transaction in flight
  logic        cur_we;
  logic [63:0] exp_mem_addr;
  logic [63:0] exp_wdata;
  logic [7:0]  exp_wstrb;
  logic [63:0] exp_rdata;
  bit          exp_mis;
  bit          exp_err;
  int          exp_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte-level view of the access: which bytes are touched, what lands in
  // each lane, and what the pipeline must get back.
  task automatic set_model(input logic we, input logic [63:0] addr, input logic [1:0] size,
                           input logic su, input logic [63:0] wd, input logic [63:0] mrd,
                           input int stall, input int rwait);
    int nb;
    int off;
    int eff_wait;
    logic fill;
    nb  = 1 << size;
    off = int'(addr[2:0]);
    cur_we       = we;
    exp_mis      = (off % nb) != 0;
    exp_mem_addr = addr - 64'(off);
    exp_wstrb    = 8'hFF;
    if (we) begin
      exp_wstrb = 8'h00;
      for (int i = 0; i < nb; i++) if (off + i < 8) exp_wstrb[off + i] = 1'b1;
    end
    for (int i = 0; i < 8; i++) exp_wdata[8*i +: 8] = wd[8*(i % nb) +: 8];
    exp_err  = 1'b0;
    eff_wait = rwait;
`ifdef LSU_TIMEOUT_EN
    if (!exp_mis && (rwait == 0 || rwait > TMO)) begin
      exp_err  = 1'b1;
      eff_wait = TMO;
    end
`endif
    if (we || exp_mis || exp_err) begin
      exp_rdata = 64'h0;
    end else begin
      fill = !su && mrd[8*(off + nb) - 1];
      for (int i = 0; i < 8; i++)
        exp_rdata[8*i +: 8] = (i < nb) ? mrd[8*(off + i) +: 8] : {8{fill}};
    end
    exp_lat = exp_mis ? 1 : 3 + stall + (eff_wait - 1);
  endtask

  task automatic compare();
    if (rst_n) begin
      check("req_ready", 64'(o_lsu_req_ready), 64'(!in_flight));
      check("mem_req_valid", 64'(o_mem_req_valid), 64'(req_phase));
      if (req_phase && o_mem_req_valid) begin
        check("mem_addr", o_mem_addr, exp_mem_addr);
        check("mem_we", 64'(o_mem_we), 64'(cur_we));
        check("mem_wstrb", 64'(o_mem_wstrb), 64'(exp_wstrb));
        if (cur_we) check("mem_wdata", o_mem_wdata, exp_wdata);
      end
      if (o_lsu_rsp_valid) begin
        if (!in_flight) begin
          checks++;
          errors++;
          $display("FAIL spurious_rsp: rsp_valid=1 with no transaction outstanding (t=%0t)", $time);
        end else begin
          check("rsp_rdata", o_lsu_rdata, exp_rdata);
          check("rsp_misalign", 64'(o_lsu_misalign), 64'(exp_mis));
          check("rsp_err", 64'(o_lsu_err), 64'(exp_err));
          check("rsp_latency", 64'(cyc - accept_cyc + 1), 64'(exp_lat));
          in_flight = 1'b0;
          rsp_cnt++;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic txn(input string nm, input logic we, input logic [63:0] addr, input logic [1:0] size,
                     input logic su, input logic [63:0] wd, input logic [63:0] mrd,
                     input int stall, input int rwait, input logic [63:0] lit_rdata,
                     input logic [7:0] lit_wstrb, input logic [63:0] lit_wdata, input int lit_lat);
    int start;
    set_model(we, addr, size, su, wd, mrd, stall, rwait);
    check({nm, "_model_rdata"}, exp_rdata, lit_rdata);
    check({nm, "_model_lat"}, 64'(exp_lat), 64'(lit_lat));
    if (!exp_mis) check({nm, "_model_wstrb"}, 64'(exp_wstrb), 64'(lit_wstrb));
    if (we && !exp_mis) check({nm, "_model_wdata"}, exp_wdata, lit_wdata);

    i_lsu_req_valid = 1'b1;
    i_lsu_we        = we;
    i_lsu_addr      = addr;
    i_lsu_size      = size;
    i_lsu_su_extend = su;
    i_lsu_wdata     = wd;
    step();
    // scramble the request inputs; the DUT must work from its captured copy
    i_lsu_req_valid = 1'b0;
    i_lsu_we        = ~we;
    i_lsu_addr      = 64'hDEAD_0000_0000_0BAD;
    i_lsu_size      = ~size;
    i_lsu_su_extend = ~su;
    i_lsu_wdata     = ~wd;
    in_flight  = 1'b1;
    accept_cyc = cyc;
    start      = rsp_cnt;
    if (!exp_mis) begin
      req_phase       = 1'b1;
      i_mem_req_ready = 1'b0;
      repeat (stall) step();
      i_mem_req_ready = 1'b1;
      step();
      i_mem_req_ready = 1'b0;
      req_phase       = 1'b0;
      if (rwait > 0) begin
        repeat (rwait - 1) step();
        i_mem_rsp_valid = 1'b1;
        i_mem_rdata     = mrd;
        step();
        i_mem_rsp_valid = 1'b0;
        i_mem_rdata     = 64'h5A5A_5A5A_5A5A_5A5A;
      end
    end
    for (int i = 0; i < TMO + 20 && rsp_cnt == start; i++) step();
    if (rsp_cnt == start) begin
      checks++;
      errors++;
      $display("FAIL %s_rsp_timeout: no rsp_valid within %0d cycles, want latency %0d", nm, TMO + 20, exp_lat);
      in_flight = 1'b0;
      req_phase = 1'b0;
    end
  endtask

  // Abandon a load by reset while in REQ (in_wait=0) or WAIT (in_wait=1),
  // then present a late memory response that must be ignored.
  task automatic reset_mid(input string nm, input bit in_wait);
    set_model(1'b0, 64'h2000, 2'b11, 1'b0, 64'h0, 64'h1111_2222_3333_4444, 1, 1);
    i_lsu_req_valid = 1'b1;
    i_lsu_we        = 1'b0;
    i_lsu_addr      = 64'h2000;
    i_lsu_size      = 2'b11;
    i_lsu_su_extend = 1'b0;
    step();
    i_lsu_req_valid = 1'b0;
    in_flight       = 1'b1;
    accept_cyc      = cyc;
    req_phase       = 1'b1;
    i_mem_req_ready = 1'b0;
    step();
    if (in_wait) begin
      i_mem_req_ready = 1'b1;
      step();
      i_mem_req_ready = 1'b0;
      req_phase       = 1'b0;
      step();
    end
    rst_n = 1'b0;
    #1;
    check({nm, "_req_valid"}, 64'(o_mem_req_valid), 64'h0);
    check({nm, "_rsp_valid"}, 64'(o_lsu_rsp_valid), 64'h0);
    check({nm, "_req_ready"}, 64'(o_lsu_req_ready), 64'h1);
    check({nm, "_mem_addr"}, o_mem_addr, 64'h0);
    check({nm, "_mem_wstrb"}, 64'(o_mem_wstrb), 64'h0);
    check({nm, "_rdata"}, o_lsu_rdata, 64'h0);
    in_flight = 1'b0;
    req_phase = 1'b0;
    step();
    rst_n           = 1'b1;
    i_mem_rsp_valid = 1'b1;
    i_mem_rdata     = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    step();
    i_mem_rsp_valid = 1'b0;
    check({nm, "_late_ready"}, 64'(o_lsu_req_ready), 64'h1);
    check({nm, "_late_rdata"}, o_lsu_rdata, 64'h0);
  endtask

  initial begin
    rst_n           = 1'b0;
    i_lsu_req_valid = 1'b0;
    i_lsu_we        = 1'b0;
    i_lsu_addr      = 64'h0;
    i_lsu_size      = 2'b00;
    i_lsu_su_extend = 1'b0;
    i_lsu_wdata     = 64'h0;
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0;
    i_mem_rdata     = 64'h0;
    #12;
    check("rst_req_ready", 64'(o_lsu_req_ready), 64'h1);
    check("rst_rsp_valid", 64'(o_lsu_rsp_valid), 64'h0);
    check("rst_mem_req_valid", 64'(o_mem_req_valid), 64'h0);
    check("rst_rdata", o_lsu_rdata, 64'h0);
    check("rst_misalign", 64'(o_lsu_misalign), 64'h0);
    check("rst_err", 64'(o_lsu_err), 64'h0);
    check("rst_mem_addr", o_mem_addr, 64'h0);
    check("rst_mem_wdata", o_mem_wdata, 64'h0);
    check("rst_mem_wstrb", 64'(o_mem_wstrb), 64'h0);
    check("rst_mem_we", 64'(o_mem_we), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    //  name        we    addr          sz     su    wdata                    mem rdata                stall rwait lit_rdata                lit_wstrb lit_wdata                lit_lat
    txn("lb_s",     1'b0, 64'h1003, 2'b00, 1'b0, 64'h0,                   64'h0000_0000_8000_0000, 0, 1, 64'hFFFF_FFFF_FFFF_FF80, 8'hFF, 64'h0,                   3);
    txn("lbu",      1'b0, 64'h1003, 2'b00, 1'b1, 64'h0,                   64'h0000_0000_8000_0000, 0, 1, 64'h0000_0000_0000_0080, 8'hFF, 64'h0,                   3);
    txn("lw_s",     1'b0, 64'h1004, 2'b10, 1'b0, 64'h0,                   64'h8000_0000_1234_5678, 0, 1, 64'hFFFF_FFFF_8000_0000, 8'hFF, 64'h0,                   3);
    txn("lwu",      1'b0, 64'h1004, 2'b10, 1'b1, 64'h0,                   64'h8000_0000_1234_5678, 2, 2, 64'h0000_0000_8000_0000, 8'hFF, 64'h0,                   6);
    txn("sh",       1'b1, 64'h1006, 2'b01, 1'b0, 64'h1234_5678_9ABC_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 64'h0,                   8'hC0, 64'hBEEF_BEEF_BEEF_BEEF, 3);
    txn("lw_mis",   1'b0, 64'h1002, 2'b10, 1'b0, 64'h0,                   64'h0,                   0, 1, 64'h0,                   8'hFF, 64'h0,                   1);
    txn("ld_stall", 1'b0, 64'h1008, 2'b11, 1'b0, 64'h0,                   64'h0123_4567_89AB_CDEF, 5, 1, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0,                   8);
    txn("lh_s",     1'b0, 64'h100A, 2'b01, 1'b0, 64'h0,                   64'h1122_3344_F00D_5566, 0, 3, 64'hFFFF_FFFF_FFFF_F00D, 8'hFF, 64'h0,                   5);
    txn("sb",       1'b1, 64'h1005, 2'b00, 1'b0, 64'h0000_0000_0000_00A5, 64'h0,                   1, 1, 64'h0,                   8'h20, 64'hA5A5_A5A5_A5A5_A5A5, 4);
    txn("sw",       1'b1, 64'h1004, 2'b10, 1'b0, 64'h0000_0000_DEAD_BEEF, 64'h0,                   0, 2, 64'h0,                   8'hF0, 64'hDEAD_BEEF_DEAD_BEEF, 4);
    txn("sd_mis",   1'b1, 64'h1004, 2'b11, 1'b0, 64'h1111_2222_3333_4444, 64'h0,                   0, 1, 64'h0,                   8'hFF, 64'h0,                   1);
    txn("sh_mis",   1'b1, 64'h1007, 2'b01, 1'b0, 64'h0000_0000_0000_1234, 64'h0,                   0, 1, 64'h0,                   8'hFF, 64'h0,                   1);
    txn("lb_top",   1'b0, 64'h1007, 2'b00, 1'b0, 64'h0,                   64'h7F11_2233_4455_6677, 0, 1, 64'h0000_0000_0000_007F, 8'hFF, 64'h0,                   3);
    txn("sd",       1'b1, 64'h1010, 2'b11, 1'b0, 64'h0102_0304_0506_0708, 64'h0,                   0, 1, 64'h0,                   8'hFF, 64'h0102_0304_0506_0708, 3);

    reset_mid("rst_req", 1'b0);
    reset_mid("rst_wait", 1'b1);

    txn("lhu_post", 1'b0, 64'h100A, 2'b01, 1'b1, 64'h0,                   64'h1122_3344_F00D_5566, 0, 1, 64'h0000_0000_0000_F00D, 8'hFF, 64'h0,                   3);
`ifdef LSU_TIMEOUT_EN
    txn("tmo_err",  1'b0, 64'h1018, 2'b11, 1'b0, 64'h0,                   64'h0,                   0, 0,   64'h0,                   8'hFF, 64'h0,                   TMO + 2);
    txn("tmo_edge", 1'b0, 64'h1018, 2'b11, 1'b0, 64'h0,                   64'h5555_6666_7777_8888, 0, TMO, 64'h5555_6666_7777_8888, 8'hFF, 64'h0,                   TMO + 2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
